uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_MAX, default 5208, clk cycles per bit (50 MHz / 9600 baud).
REQ-002 Parameter SAMPLE_PT, default BAUD_MAX/2, cycle within a bit at which the line is sampled.
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port uart_rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 Port rx_data  output  8  last correctly received byte, LSB first on the line.
REQ-007 Port rx_valid  output  1  one-cycle pulse, rx_data updated this cycle.
REQ-008 Port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 Port parity_err  output  1  one-cycle pulse, parity mismatch (tied 0 without UART_RX_PARITY_EN).

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-011 A start is a 1->0 transition of the synchronized line, detected with one further register; a line held low SHALL NOT retrigger.
REQ-012 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE->START on start detect; baud counter cleared to 0 on that cycle.
REQ-014 The baud counter SHALL count 0..BAUD_MAX-1 and wrap, running only outside IDLE; it is held at 0 in IDLE.
REQ-015 Sampling SHALL occur when the counter equals SAMPLE_PT-1.
REQ-016 START: sample high -> IDLE (glitch rejected, no pulse); sample low -> continue; leave START at counter wrap.
REQ-017 DATA: 8 bits, bit counter 0..7; sampled bit k SHALL go to shift-register position k; DATA->next state at wrap after bit 7.
REQ-018 STOP: sample high -> rx_data <= shift register and rx_valid=1 on the cycle after the sample, then IDLE; no wait for the end of the bit.
REQ-019 STOP: sample low -> frame_err=1 on the cycle after the sample, rx_data unchanged, rx_valid=0, then IDLE.
REQ-020 Latency: rx_valid SHALL assert 2+(9*BAUD_MAX)+SAMPLE_PT clk cycles (+BAUD_MAX with parity) after the uart_rx falling edge, ±1 cycle.
REQ-021 rx_valid, frame_err and parity_err SHALL be mutually exclusive and never assert for two consecutive cycles.
REQ-022 rx_data SHALL hold its value between valid pulses.
REQ-023 Back-to-back frames (stop bit directly followed by start) SHALL be received without loss.

Reset
REQ-024 On rst_n low: FSM=IDLE, counters=0, synchronizer and edge flops=1, rx_data=8'h00, rx_valid=0, frame_err=0, parity_err=0.
REQ-025 Reset mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL resume only on a fresh 1->0 edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: a PARITY state follows DATA; even parity is checked over the 8 data bits and the parity bit.
REQ-027 With UART_RX_PARITY_EN, a mismatch SHALL cause parity_err pulse instead of rx_valid at the stop-sample point (if stop is also low, frame_err takes priority); rx_data unchanged.
REQ-028 Without UART_RX_PARITY_EN: 8N1 only; no PARITY state; parity_err constant 0.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encoding, the default BAUD_MAX (5208) and the frame bit counts, shared with the transmitter.
REQ-030 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for uart_rx.

Verification
REQ-031 Byte 8'h0F sent 8N1 at BAUD_MAX=5208 -> one rx_valid pulse, rx_data=8'h0F, within the REQ-020 window.
REQ-032 Low glitch of 100 cycles on an idle line -> no pulse; FSM back in IDLE; the next byte 8'hA5 is received correctly.
REQ-033 Byte 8'h3C with stop bit forced low -> frame_err pulse, rx_data keeps its previous value, no rx_valid.
REQ-034 Frames 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three rx_valid pulses carrying the correct data.
REQ-035 rst_n pulsed low during bit 4 of 8'hC3 -> no pulse, outputs at reset values; the next frame 8'h81 is received correctly.
REQ-036 With UART_RX_PARITY_EN: 8'h07 sent with parity bit 0 (wrong) -> parity_err pulse; sent with parity bit 1 -> rx_valid, rx_data=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, default bit period and frame bit counts.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int BAUD_MAX_DEF = 5208;
   localparam int DATA_BITS    = 8;
   localparam int STOP_BITS    = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_state_e;

   // Even parity holds when data plus parity bit carry an even number of ones.
   function automatic logic even_par_ok(input logic [DATA_BITS-1:0] d, input logic p);
      return ~(^{d, p});
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signals: serial line in, received byte and status pulses out.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 uart_rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 parity_err;

   modport master (
      input  uart_rx,
      output rx_data,
      output rx_valid,
      output frame_err,
      output parity_err
   );

   modport slave (
      output uart_rx,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  parity_err
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined; samples each bit
// once at SAMPLE_PT-1 of a BAUD_MAX-cycle bit period and pulses result flags one cycle later.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_MAX  = BAUD_MAX_DEF,
   parameter int SAMPLE_PT = BAUD_MAX / 2
) (
   input logic       clk,
   input logic       rst_n,
   uart_rx_if.master rx_if
);

   localparam int CW = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t       SMP_AT   = cnt_t'(SAMPLE_PT - 1);
   localparam cnt_t       WRAP_AT  = cnt_t'(BAUD_MAX - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic                 line_s;
   logic                 prev_q;
   logic [1:0]           live_q;
   logic                 armed_q;
   logic                 start_det;
   logic                 smp;
   logic                 wrap;

   uart_state_e          state_q, state_d;
   cnt_t                 cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 parity_err_q, parity_err_d;
`endif

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx_if.uart_rx),
      .q_o   (line_s)
   );

   // The synchronizer and edge flop reset to 1, which is not a real observation of the line.
   // Start detection is armed only after a genuine high has been seen, so a line that is
   // low when reset releases cannot fake a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= 1'b1;
         live_q  <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= line_s;
         live_q  <= {live_q[0], 1'b1};
         armed_q <= armed_q | (live_q[1] & line_s);
      end
   end

   assign start_det = armed_q & prev_q & ~line_s;
   assign smp       = (cnt_q == SMP_AT);
   assign wrap      = (cnt_q == WRAP_AT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = wrap ? '0 : cnt_q + cnt_t'(1);
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (start_det) begin
               state_d = START;
            end
         end

         START: begin
            if (smp && line_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (wrap) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end

         DATA: begin
            if (smp) begin
               shreg_d[bit_q] = line_s;
            end
            if (wrap) begin
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
                  bit_d = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (smp) begin
               par_d = line_s;
            end
            if (wrap) begin
               state_d = STOP;
            end
         end
`endif

         // Result is decided at the stop sample; the rest of the stop bit is spent in IDLE
         // so a back-to-back start edge is never missed.
         STOP: begin
            if (smp) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (!line_s) begin
                  frame_err_d = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               else if (!even_par_ok(shreg_q, par_q)) begin
                  parity_err_d = 1'b1;
               end
`endif
               else begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = shreg_q;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_valid  = rx_valid_q;
   assign rx_if.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err = parity_err_q;
`else
   assign rx_if.parity_err = 1'b0;
`endif

endmodule
